// File: rtl/mul_div_if.sv
// mul_div_if -- request/response bundle between the control unit and the
// multiply/divide unit.
//
// Handshake: the master raises start (with op_div, a, b and, when built with
// MULDIV_UNSIGNED_EN, unsigned_op) for one or more cycles; the unit accepts it
// on the first rising edge where it is idle (busy low) and latches the operands
// on that edge. start is ignored while busy is high. done is a one-cycle pulse
// marking z_hi/z_lo/div_by_zero valid; z_hi/z_lo then hold until the next
// result or reset, div_by_zero holds until the next accepted start.
//
// Signals:
//   start        master->unit  request an operation
//   op_div       master->unit  0 = multiply, 1 = divide
//   a, b         master->unit  operands (a from Y, b from BusMuxOut)
//   unsigned_op  master->unit  only with MULDIV_UNSIGNED_EN: unsigned operands
//   busy         unit->master  operation in progress
//   done         unit->master  result valid pulse
//   div_by_zero  unit->master  last divide had b == 0
//   z_hi, z_lo   unit->master  result halves
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULDIV_UNSIGNED_EN
  logic             unsigned_op;
`endif
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] z_hi;
  logic [WIDTH-1:0] z_lo;

  modport master (
    output start, op_div, a, b,
`ifdef MULDIV_UNSIGNED_EN
    output unsigned_op,
`endif
    input  busy, done, div_by_zero, z_hi, z_lo
  );

  modport slave (
    input  start, op_div, a, b,
`ifdef MULDIV_UNSIGNED_EN
    input  unsigned_op,
`endif
    output busy, done, div_by_zero, z_hi, z_lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit -- multi-cycle signed multiply/divide feeding the Z_HI/Z_LO
// register pair. Multiply is radix-2 Booth, divide is restoring division on
// operand magnitudes followed by a sign fix-up. One iteration per clock,
// WIDTH iterations, then a FIX cycle and a one-cycle DONE.
//
// Optional feature macro: MULDIV_UNSIGNED_EN adds bus.unsigned_op; when set
// with start, both operands are treated as unsigned.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   bus        mul_div_if.slave (start/op_div/a/b in, busy/done/results out)
//   dbg_state  current FSM state encoding (IDLE=0, MUL=1, DIV=2, FIX=3, DONE=4)
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       clr,
  mul_div_if.slave   bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  // acc_hi/acc_lo: Booth partial product (hi sign-extended by one bit) or
  // remainder/quotient during divide.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] a_reg;
  logic             is_div;
  logic             uns;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] z_hi_q;
  logic [WIDTH-1:0] z_lo_q;
  logic             dbz_q;

  logic             uns_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             last_iter;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef MULDIV_UNSIGNED_EN
  assign uns_in = bus.unsigned_op;
`else
  assign uns_in = 1'b0;
`endif

  assign abs_a     = (!uns_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b     = (!uns_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!bus.op_div)        state_nx = MUL;
          else if (bus.b != '0)   state_nx = DIV;
          else                    state_nx = DONE;
        end
      end
      MUL, DIV: if (last_iter) state_nx = FIX;
      FIX:      state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // One Booth step: inspect {multiplier lsb, previous lsb}.
  always_comb begin
    m_ext = {m_reg[WIDTH-1], m_reg};
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = acc_hi + m_ext;
      2'b10:   booth_sum = acc_hi - m_ext;
      default: booth_sum = acc_hi;
    endcase
  end

  // One restoring-divide step; two guard bits so an unsigned divisor with its
  // top bit set still yields a correct sign on the trial subtraction.
  assign trial = {1'b0, acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]} - {2'b00, m_reg};

  // Final result. The unsigned product is the signed Booth product with the
  // high half corrected by each operand whose top bit was set (mod 2^WIDTH).
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_div) begin
      res_lo = neg_q ? -acc_lo : acc_lo;
      res_hi = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    end else begin
      res_lo = acc_lo;
      res_hi = acc_hi[WIDTH-1:0]
             + ((uns && a_reg[WIDTH-1]) ? m_reg : '0)
             + ((uns && m_reg[WIDTH-1]) ? a_reg : '0);
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      q_m1   <= 1'b0;
      m_reg  <= '0;
      a_reg  <= '0;
      is_div <= 1'b0;
      uns    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      z_hi_q <= '0;
      z_lo_q <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dbz_q  <= 1'b0;
            cnt    <= '0;
            uns    <= uns_in;
            a_reg  <= bus.a;
            is_div <= bus.op_div;
            acc_hi <= '0;
            q_m1   <= 1'b0;
            if (!bus.op_div) begin
              acc_lo <= bus.a;
              m_reg  <= bus.b;
            end else if (bus.b != '0) begin
              acc_lo <= abs_a;
              m_reg  <= abs_b;
              neg_q  <= !uns_in && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_r  <= !uns_in && bus.a[WIDTH-1];
            end else begin
              // Divide by zero skips straight to DONE with a fixed result.
              z_hi_q <= bus.a;
              z_lo_q <= '1;
              dbz_q  <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
          q_m1   <= acc_lo[0];
          cnt    <= cnt + 1'b1;
        end
        DIV: begin
          if (!trial[WIDTH+1]) begin
            acc_hi <= trial[WIDTH:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          z_hi_q <= res_hi;
          z_lo_q <= res_lo;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.z_hi        = z_hi_q;
  assign bus.z_lo        = z_lo_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- directed test of mul_div_unit. Stimulus tasks push the
// expected {div_by_zero, z_hi, z_lo} into exp_q; a monitor pops and compares
// on every done pulse. Latency, busy and reset behaviour are checked inline.
module tb_mul_div_unit;
  localparam int W = 32;

  logic       clk;
  logic       clr;
  logic [2:0] dbg_state;

  mul_div_if #(.WIDTH(W)) bus();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int issued   = 0;

  logic [2*W:0] exp_q[$];

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [2*W:0] e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("z_hi", {32'd0, bus.z_hi}, {32'd0, e[2*W-1:W]});
          check("z_lo", {32'd0, bus.z_lo}, {32'd0, e[W-1:0]});
          check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e[2*W]});
        end
      end
    end
  end

  // Issue one operation; start is sampled on edge 1. poke > 0 re-pulses start
  // (as a divide by zero) so that edge number poke samples it while busy.
  task automatic issue(input logic div, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                       input int lat, input int poke);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = div;
    bus.a      = a_v;
    bus.b      = b_v;
    exp_q.push_back({edz, eh, el});
    issued++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    check("busy_edge1", {63'd0, bus.busy}, 64'd1);
    check("dbz_edge1", {63'd0, bus.div_by_zero}, {63'd0, edz});
    n    = 1;
    seen = bus.done;
    while (!seen && n < 100) begin
      if (n == poke - 1) begin
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
        bus.b      = '0;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
      seen = bus.done;
      if (!seen) check("busy_during", {63'd0, bus.busy}, 64'd1);
    end
    check("latency", 64'(n), 64'(lat));
    @(posedge clk); #1;
    check("busy_after", {63'd0, bus.busy}, 64'd0);
    check("done_after", {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int d0;
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
`ifdef MULDIV_UNSIGNED_EN
    bus.unsigned_op = 1'b0;
`endif
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    check("rst_z_hi", {32'd0, bus.z_hi}, 64'd0);
    check("rst_z_lo", {32'd0, bus.z_lo}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    @(negedge clk);
    clr = 1'b0;

    // multiplies
    issue(1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 0);
    issue(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 0);
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34, 0);
    issue(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34, 0);
    issue(1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 34, 0);

    // divides
    issue(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 0);
    issue(1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 0);
    issue(1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34, 0);
    issue(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 34, 0);

    // divide by zero; flag holds in IDLE, next start clears it (dbz_edge1)
    issue(1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("dbz_hold", {63'd0, bus.div_by_zero}, 64'd1);
    check("dbz_z_hold", {32'd0, bus.z_hi}, 64'd5);

    // divide overflow wraps
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 0);

    // start while busy is ignored: exactly one done
    d0 = done_cnt;
    issue(1'b0, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 34, 5);
    repeat (5) @(posedge clk);
    #1;
    check("one_done", 64'(done_cnt - d0), 64'd1);
    check("no_dbz_after_poke", {63'd0, bus.div_by_zero}, 64'd0);

    // clr mid-operation
    d0 = done_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    bus.a      = 32'd3;
    bus.b      = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_busy", {63'd0, bus.busy}, 64'd0);
    check("clr_z_hi", {32'd0, bus.z_hi}, 64'd0);
    check("clr_z_lo", {32'd0, bus.z_lo}, 64'd0);
    check("clr_state", {61'd0, dbg_state}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("clr_no_done", 64'(done_cnt - d0), 64'd0);

    // clr and start together: start dropped
    @(negedge clk);
    clr       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    clr       = 1'b0;
    bus.start = 1'b0;
    check("clr_start_busy", {63'd0, bus.busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("clr_start_no_done", 64'(done_cnt - d0), 64'd0);

    issue(1'b0, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, 34, 0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_total", 64'(done_cnt), 64'(issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
